rom_dl_ctrl: RTL and testbench

ROM_DL_CTRL -- requirements
Module: rom_dl_ctrl

---
 rtl/rom_dl_pkg.sv | 33 +++
 rtl/dl_byte_fifo.sv | 51 +++++
 rtl/rom_dl_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_rom_dl_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_dl_pkg.sv
// rtl/rom_dl_pkg.sv - shared types and helpers for the ROM download controller
package rom_dl_pkg;

    localparam logic [24:0] GFX_BASE_DEFAULT = 25'h10000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT1 = 2'd2,
        ST_WAIT2 = 2'd3
    } dl_state_e;

    typedef struct packed {
        logic [24:0] addr;
        logic [7:0]  data;
    } dl_entry_t;

    typedef struct packed {
        logic [22:0] a;
        logic [1:0]  ds;
        logic [15:0] d;
    } port_cmd_t;

    // Byte address within a port region -> 16-bit word write with a single byte lane enabled
    function automatic port_cmd_t map_cmd(input logic [23:0] offs, input logic [7:0] data);
        port_cmd_t c;
        c.a  = offs[23:1];
        c.ds = {offs[0], ~offs[0]};
        c.d  = {data, data};
        return c;
    endfunction

endpackage

// File: rtl/dl_byte_fifo.sv
// rtl/dl_byte_fifo.sv - small synchronous queue of download bytes with their addresses
module dl_byte_fifo
    import rom_dl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk_sys,
    input  logic      reset_n,
    input  logic      push_i,
    input  dl_entry_t push_data_i,
    input  logic      pop_i,
    output dl_entry_t pop_data_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int AW = $clog2(DEPTH);

    dl_entry_t       mem_q [DEPTH];
    logic [AW:0]     wr_ptr_q;
    logic [AW:0]     rd_ptr_q;
    logic            do_push;
    logic            do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push    = push_i & ~full_o;
    assign do_pop     = pop_i & ~empty_o;
    assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

    // Storage array; contents need no reset since the pointers gate visibility
    always_ff @(posedge clk_sys) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

    // Read/write pointer advance; a push into a full queue leaves it untouched
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/rom_dl_ctrl.sv
// rtl/rom_dl_ctrl.sv - routes ioctl download bytes to two toggle-handshake SDRAM ports
module rom_dl_ctrl
    import rom_dl_pkg::*;
#(
    parameter logic [24:0] GFX_BASE   = GFX_BASE_DEFAULT,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_downl,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        port1_req,
    input  logic        port1_ack,
    output logic [22:0] port1_a,
    output logic [1:0]  port1_ds,
    output logic [15:0] port1_d,
    output logic        port1_we,
    output logic        port2_req,
    input  logic        port2_ack,
    output logic [22:0] port2_a,
    output logic [1:0]  port2_ds,
    output logic [15:0] port2_d,
    output logic        port2_we,
    input  logic        user_reset,
    output logic        core_reset,
    output logic        rom_loaded,
    output logic        overflow,
    output logic [24:0] byte_count
);

    dl_state_e   state_q, state_d;
    logic        wr_q;
    logic        downl_q;
    logic        fell_seen_q;
    logic        rom_loaded_q, rom_loaded_d;
    logic        core_reset_q;
    logic        overflow_q;
    logic [24:0] byte_count_q, byte_count_d;

    logic        p1_req_q, p2_req_q;
    logic        p1_we_q, p2_we_q;
    port_cmd_t   p1_cmd_q, p2_cmd_q;

    logic        push_req;
    logic        downl_rise;
    logic        downl_fall;
    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;
    logic        issue1;
    logic        issue2;
    logic        done;
    dl_entry_t   push_entry;
    dl_entry_t   head;
    logic        head_is_gfx;
    logic [23:0] head_offs;
    port_cmd_t   head_cmd;

    assign push_req   = ioctl_wr & ~wr_q & ioctl_downl & (ioctl_index == 8'd0);
    assign downl_rise = ioctl_downl & ~downl_q;
    assign downl_fall = ~ioctl_downl & downl_q;
    assign push_entry = '{addr: ioctl_addr, data: ioctl_dout};

    dl_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .push_i      (push_req),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .pop_data_o  (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Region select; only the low 24 offset bits reach the 23-bit word address
    assign head_is_gfx = (head.addr >= GFX_BASE);
    assign head_offs   = head_is_gfx ? (head.addr[23:0] - GFX_BASE[23:0]) : head.addr[23:0];
    assign head_cmd    = map_cmd(head_offs, head.data);

    // Dispatcher state register
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Dispatcher next state: one request in flight at a time across both ports
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        issue1  = 1'b0;
        issue2  = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                pop = 1'b1;
                if (head_is_gfx) begin
                    issue2  = 1'b1;
                    state_d = ST_WAIT2;
                end else begin
                    issue1  = 1'b1;
                    state_d = ST_WAIT1;
                end
            end
            ST_WAIT1: begin
                if (port1_ack == p1_req_q) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT2: begin
                if (port2_ack == p2_req_q) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Port 1 fields are only rewritten on issue, so they hold while req != ack
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            p1_req_q <= 1'b0;
            p1_cmd_q <= '0;
            p1_we_q  <= 1'b0;
        end else if (issue1) begin
            p1_req_q <= ~p1_req_q;
            p1_cmd_q <= head_cmd;
            p1_we_q  <= ioctl_downl;
        end
    end

    // Port 2 (graphics region) request fields
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            p2_req_q <= 1'b0;
            p2_cmd_q <= '0;
            p2_we_q  <= 1'b0;
        end else if (issue2) begin
            p2_req_q <= ~p2_req_q;
            p2_cmd_q <= head_cmd;
            p2_we_q  <= ioctl_downl;
        end
    end

    // Status next state; a restart clears the count even if a commit lands the same cycle
    always_comb begin
        byte_count_d = byte_count_q;
        rom_loaded_d = rom_loaded_q;
        if (downl_rise) begin
            byte_count_d = '0;
        end else if (done) begin
            byte_count_d = byte_count_q + 25'd1;
        end
        if (downl_rise) begin
            rom_loaded_d = 1'b0;
        end else if (!ioctl_downl && (fell_seen_q || downl_fall) &&
                     fifo_empty && (state_q == ST_IDLE)) begin
            rom_loaded_d = 1'b1;
        end
    end

    // Edge detectors, sticky overflow, load status and registered core reset
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_q         <= 1'b0;
            downl_q      <= 1'b0;
            fell_seen_q  <= 1'b0;
            rom_loaded_q <= 1'b0;
            core_reset_q <= 1'b1;
            overflow_q   <= 1'b0;
            byte_count_q <= '0;
        end else begin
            wr_q         <= ioctl_wr;
            downl_q      <= ioctl_downl;
            rom_loaded_q <= rom_loaded_d;
            byte_count_q <= byte_count_d;
            core_reset_q <= user_reset | ~rom_loaded_q | ioctl_downl;
            if (downl_rise)               fell_seen_q <= 1'b0;
            else if (downl_fall)          fell_seen_q <= 1'b1;
            if (push_req && fifo_full)    overflow_q  <= 1'b1;
        end
    end

    assign port1_req  = p1_req_q;
    assign port1_a    = p1_cmd_q.a;
    assign port1_ds   = p1_cmd_q.ds;
    assign port1_d    = p1_cmd_q.d;
    assign port1_we   = p1_we_q;
    assign port2_req  = p2_req_q;
    assign port2_a    = p2_cmd_q.a;
    assign port2_ds   = p2_cmd_q.ds;
    assign port2_d    = p2_cmd_q.d;
    assign port2_we   = p2_we_q;
    assign core_reset = core_reset_q;
    assign rom_loaded = rom_loaded_q;
    assign overflow   = overflow_q;
    assign byte_count = byte_count_q;

endmodule

// File: tb/tb_rom_dl_ctrl.sv
// tb/tb_rom_dl_ctrl.sv - self-checking bench for rom_dl_ctrl
module tb_rom_dl_ctrl;

    logic        clk_sys;
    logic        reset_n;
    logic        ioctl_downl;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        port1_req, port1_ack, port1_we;
    logic [22:0] port1_a;
    logic [1:0]  port1_ds;
    logic [15:0] port1_d;
    logic        port2_req, port2_ack, port2_we;
    logic [22:0] port2_a;
    logic [1:0]  port2_ds;
    logic [15:0] port2_d;
    logic        user_reset;
    logic        core_reset;
    logic        rom_loaded;
    logic        overflow;
    logic [24:0] byte_count;

    rom_dl_ctrl #(
        .GFX_BASE   (25'h10000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ioctl_downl (ioctl_downl),
        .ioctl_index (ioctl_index),
        .ioctl_wr    (ioctl_wr),
        .ioctl_addr  (ioctl_addr),
        .ioctl_dout  (ioctl_dout),
        .port1_req   (port1_req),
        .port1_ack   (port1_ack),
        .port1_a     (port1_a),
        .port1_ds    (port1_ds),
        .port1_d     (port1_d),
        .port1_we    (port1_we),
        .port2_req   (port2_req),
        .port2_ack   (port2_ack),
        .port2_a     (port2_a),
        .port2_ds    (port2_ds),
        .port2_d     (port2_d),
        .port2_we    (port2_we),
        .user_reset  (user_reset),
        .core_reset  (core_reset),
        .rom_loaded  (rom_loaded),
        .overflow    (overflow),
        .byte_count  (byte_count)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // SDRAM-side responder: echoes req onto ack after ack_delay cycles when enabled
    logic ack_en;
    int   ack_delay;
    initial begin
        int c1 = 0;
        int c2 = 0;
        port1_ack = 1'b0;
        port2_ack = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (!reset_n) begin
                port1_ack = 1'b0;
                port2_ack = 1'b0;
                c1 = 0;
                c2 = 0;
            end else begin
                if (ack_en && (port1_req != port1_ack)) begin
                    c1++;
                    if (c1 >= ack_delay) begin
                        port1_ack = port1_req;
                        c1 = 0;
                    end
                end
                if (ack_en && (port2_req != port2_ack)) begin
                    c2++;
                    if (c2 >= ack_delay) begin
                        port2_ack = port2_req;
                        c2 = 0;
                    end
                end
            end
        end
    end

    // Port fields must not move while a request is outstanding
    int          stab_err = 0;
    logic        prev_r1 = 1'b0;
    logic        prev_r2 = 1'b0;
    logic [41:0] prev_f1 = '0;
    logic [41:0] prev_f2 = '0;
    always @(negedge clk_sys) begin
        if (reset_n) begin
            if (port1_req == prev_r1 && port1_req != port1_ack &&
                {port1_a, port1_ds, port1_d, port1_we} != prev_f1)
                stab_err <= stab_err + 1;
            if (port2_req == prev_r2 && port2_req != port2_ack &&
                {port2_a, port2_ds, port2_d, port2_we} != prev_f2)
                stab_err <= stab_err + 1;
        end
        prev_r1 <= port1_req;
        prev_r2 <= port2_req;
        prev_f1 <= {port1_a, port1_ds, port1_d, port1_we};
        prev_f2 <= {port2_a, port2_ds, port2_d, port2_we};
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic send_byte(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] data);
        @(negedge clk_sys);
        ioctl_index = idx;
        ioctl_addr  = addr;
        ioctl_dout  = data;
        ioctl_wr    = 1'b1;
        @(negedge clk_sys);
        ioctl_wr    = 1'b0;
    endtask

    task automatic wait_req(input int port, input logic prev, input string name);
        int   n;
        logic r;
        logic e;
        n = 0;
        r = (port == 1) ? port1_req : port2_req;
        while (r == prev && n < 40) begin
            @(negedge clk_sys);
            n++;
            r = (port == 1) ? port1_req : port2_req;
        end
        e = ~prev;
        check(name, r, e);
    endtask

    task automatic wait_count(input logic [24:0] exp, input string name);
        int n;
        n = 0;
        while (byte_count != exp && n < 80) begin
            @(negedge clk_sys);
            n++;
        end
        check(name, byte_count, exp);
    endtask

    typedef struct {
        logic [7:0]  idx;
        logic [24:0] addr;
        logic [7:0]  data;
        int          port;
        logic [22:0] a;
        logic [1:0]  ds;
        logic [15:0] d;
    } vec_t;

    vec_t        vecs [7];
    logic        p1prev, p2prev, tmp;
    logic [24:0] exp_cnt;
    logic [7:0]  b;
    logic [15:0] ed;

    initial begin
        vecs[0] = '{8'd0, 25'h0000003, 8'hA5, 1, 23'h000001, 2'b10, 16'hA5A5};
        vecs[1] = '{8'd0, 25'h0010000, 8'h3C, 2, 23'h000000, 2'b01, 16'h3C3C};
        vecs[2] = '{8'd0, 25'h000FFFF, 8'h5A, 1, 23'h007FFF, 2'b10, 16'h5A5A};
        vecs[3] = '{8'd0, 25'h0010001, 8'h81, 2, 23'h000000, 2'b10, 16'h8181};
        vecs[4] = '{8'd0, 25'h1FFFFFF, 8'hFF, 2, 23'h7F7FFF, 2'b10, 16'hFFFF};
        vecs[5] = '{8'd0, 25'h0000010, 8'h00, 1, 23'h000008, 2'b01, 16'h0000};
        vecs[6] = '{8'd1, 25'h0000020, 8'h11, 0, 23'h000000, 2'b00, 16'h0000};

        reset_n     = 1'b0;
        ioctl_downl = 1'b0;
        ioctl_index = 8'd0;
        ioctl_wr    = 1'b0;
        ioctl_addr  = '0;
        ioctl_dout  = '0;
        user_reset  = 1'b0;
        ack_en      = 1'b1;
        ack_delay   = 5;
        repeat (3) @(negedge clk_sys);

        check("rst_port1_req", port1_req, 0);
        check("rst_port2_req", port2_req, 0);
        check("rst_port1_a", port1_a, 0);
        check("rst_core_reset", core_reset, 1);
        check("rst_rom_loaded", rom_loaded, 0);
        check("rst_overflow", overflow, 0);
        check("rst_byte_count", byte_count, 0);

        reset_n = 1'b1;
        @(negedge clk_sys);
        ioctl_downl = 1'b1;
        @(negedge clk_sys);
        check("dl_core_reset", core_reset, 1);

        // Table-driven single-byte routing
        exp_cnt = '0;
        p1prev  = 1'b0;
        p2prev  = 1'b0;
        for (int i = 0; i < 7; i++) begin
            send_byte(vecs[i].idx, vecs[i].addr, vecs[i].data);
            if (vecs[i].port == 0) begin
                repeat (10) @(negedge clk_sys);
                check("ign_port1_req", port1_req, p1prev);
                check("ign_port2_req", port2_req, p2prev);
                check("ign_byte_count", byte_count, exp_cnt);
            end else if (vecs[i].port == 1) begin
                wait_req(1, p1prev, "vec_p1_toggle");
                check("vec_p1_a", port1_a, vecs[i].a);
                check("vec_p1_ds", port1_ds, vecs[i].ds);
                check("vec_p1_d", port1_d, vecs[i].d);
                check("vec_p1_we", port1_we, 1);
                check("vec_p2_req_quiet", port2_req, p2prev);
                tmp = ~p1prev;
                p1prev = tmp;
                exp_cnt = exp_cnt + 25'd1;
                wait_count(exp_cnt, "vec_byte_count");
            end else begin
                wait_req(2, p2prev, "vec_p2_toggle");
                check("vec_p2_a", port2_a, vecs[i].a);
                check("vec_p2_ds", port2_ds, vecs[i].ds);
                check("vec_p2_d", port2_d, vecs[i].d);
                check("vec_p2_we", port2_we, 1);
                check("vec_p1_req_quiet", port1_req, p1prev);
                tmp = ~p2prev;
                p2prev = tmp;
                exp_cnt = exp_cnt + 25'd1;
                wait_count(exp_cnt, "vec_byte_count");
            end
        end

        // Overflow: acks withheld, six strobes into a four-entry queue
        ack_en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k == 5) check("ovf_before_6th", overflow, 0);
            b = 8'h10 + 8'(k);
            send_byte(8'd0, 25'h100 + 25'(k), b);
        end
        @(negedge clk_sys);
        check("ovf_sticky", overflow, 1);
        tmp = ~p1prev;
        check("ovf_first_issued", port1_req, tmp);
        p1prev = tmp;
        check("ovf_first_data", port1_d, 16'h1010);
        check("ovf_count_hold", byte_count, exp_cnt);
        ack_en = 1'b1;
        for (int k = 1; k < 5; k++) begin
            wait_req(1, p1prev, "ovf_drain_toggle");
            tmp = ~p1prev;
            p1prev = tmp;
            b  = 8'h10 + 8'(k);
            ed = {b, b};
            check("ovf_drain_order", port1_d, ed);
        end
        exp_cnt = exp_cnt + 25'd5;
        wait_count(exp_cnt, "ovf_byte_count");
        repeat (10) @(negedge clk_sys);
        check("ovf_no_sixth", port1_req, p1prev);

        // End of download with bytes still queued
        ack_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            b = 8'h60 + 8'(k);
            send_byte(8'd0, 25'h200 + 25'(k), b);
        end
        @(negedge clk_sys);
        ioctl_downl = 1'b0;
        repeat (3) @(negedge clk_sys);
        check("eod_rom_loaded_busy", rom_loaded, 0);
        check("eod_core_reset_busy", core_reset, 1);
        ack_en = 1'b1;
        exp_cnt = exp_cnt + 25'd3;
        wait_count(exp_cnt, "eod_byte_count");
        check("eod_rom_loaded_at_last_ack", rom_loaded, 0);
        @(negedge clk_sys);
        check("eod_rom_loaded_set", rom_loaded, 1);
        check("eod_core_reset_lag", core_reset, 1);
        @(negedge clk_sys);
        check("eod_core_reset_fall", core_reset, 0);
        user_reset = 1'b1;
        @(negedge clk_sys);
        check("user_reset_assert", core_reset, 1);
        user_reset = 1'b0;
        @(negedge clk_sys);
        check("user_reset_release", core_reset, 0);
        tmp = ~p1prev;
        p1prev = tmp;

        // Download restart clears count, keeps overflow
        ioctl_downl = 1'b1;
        @(negedge clk_sys);
        check("restart_byte_count", byte_count, 0);
        check("restart_overflow_kept", overflow, 1);
        check("restart_rom_loaded", rom_loaded, 0);
        check("restart_core_reset", core_reset, 1);

        // Asynchronous reset while waiting on port 1
        ack_en = 1'b0;
        send_byte(8'd0, 25'h40, 8'h77);
        wait_req(1, p1prev, "wait1_toggle");
        check("wait1_d", port1_d, 16'h7777);
        reset_n = 1'b0;
        #1;
        check("arst_port1_req", port1_req, 0);
        check("arst_port2_req", port2_req, 0);
        check("arst_port1_a", port1_a, 0);
        check("arst_port1_ds", port1_ds, 0);
        check("arst_port1_d", port1_d, 0);
        check("arst_port1_we", port1_we, 0);
        check("arst_port2_a", port2_a, 0);
        check("arst_rom_loaded", rom_loaded, 0);
        check("arst_core_reset", core_reset, 1);
        check("arst_overflow", overflow, 0);
        check("arst_byte_count", byte_count, 0);
        ack_en = 1'b1;
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (10) @(negedge clk_sys);
        check("post_rst_idle_req", port1_req, 0);

        check("field_stability", stab_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
